// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: port identifiers, width defaults
// and the registered response record.
package dmem_arb_pkg;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;

   typedef enum logic {
      PORT_CORE = 1'b0,
      PORT_DBG  = 1'b1
   } port_id_t;

   typedef struct packed {
      logic                  valid;
      port_id_t              port;
      logic                  err;
      logic [DEF_DATA_W-1:0] data;
   } resp_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker; the last-grant history flop is kept by the caller.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic [1:0] gnt,
   output logic       gnt_id
);

   always_comb begin
      gnt    = 2'b00;
      gnt_id = 1'b0;
      // On contention the port that did not win most recently takes the slot
      if (req == 2'b11) begin
         gnt_id = ~last_grant;
      end else begin
         gnt_id = req[1];
      end
      if (req != 2'b00) begin
         gnt = gnt_id ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-ported data memory between the core (port 0) and a
// debug/loader master (port 1), one word access per cycle, round-robin.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p0_gnt,
   output logic              p1_gnt,
   output logic              p0_rvalid,
   output logic              p1_rvalid,
   output logic [DATA_W-1:0] p0_rdata,
   output logic [DATA_W-1:0] p1_rdata,
   output logic              p0_err,
   output logic              p1_err,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   logic [1:0]        arb_gnt;
   logic [1:0]        gnt;
   logic              gnt_id;
   logic              granted;
   logic              sel_we;
   logic              aligned;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   port_id_t          last_grant;
   resp_t             resp;

   rr_arb2 u_arb (
      .req        ({p1_req, p0_req}),
      .last_grant (last_grant),
      .gnt        (arb_gnt),
      .gnt_id     (gnt_id)
   );

   // Grant cycle: reset gates the grant so no write can land while it is high
   assign gnt     = reset ? 2'b00 : arb_gnt;
   assign granted = |gnt;
   assign p0_gnt  = gnt[0];
   assign p1_gnt  = gnt[1];

   always_comb begin
      sel_we    = p0_we;
      sel_addr  = p0_addr;
      sel_wdata = p0_wdata;
      if (gnt_id) begin
         sel_we    = p1_we;
         sel_addr  = p1_addr;
         sel_wdata = p1_wdata;
      end
   end

   assign aligned   = (sel_addr[1:0] == 2'b00);
   assign mem_we    = granted & sel_we & aligned;
   assign mem_addr  = granted ? sel_addr : '0;
   assign mem_wdata = granted ? sel_wdata : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant <= PORT_DBG;
      end else if (granted) begin
         last_grant <= port_id_t'(gnt_id);
      end
   end

   // Response cycle: misaligned accesses and writes return zero data
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         resp <= '0;
      end else begin
         resp.valid <= granted;
         resp.port  <= port_id_t'(gnt_id);
         resp.err   <= granted & ~aligned;
         resp.data  <= (granted & aligned & ~sel_we) ? DEF_DATA_W'(mem_rdata) : '0;
      end
   end

   assign p0_rvalid = resp.valid && (resp.port == PORT_CORE);
   assign p1_rvalid = resp.valid && (resp.port == PORT_DBG);
   assign p0_rdata  = p0_rvalid ? DATA_W'(resp.data) : '0;
   assign p1_rdata  = p1_rvalid ? DATA_W'(resp.data) : '0;
   assign p0_err    = p0_rvalid & resp.err;
   assign p1_err    = p1_rvalid & resp.err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed scoreboard bench for dmem_arbiter with a behavioural
// synchronous-write / combinational-read memory attached.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        p0_req, p0_we, p1_req, p1_we;
   logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
   logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err;
   logic [31:0] p0_rdata, p1_rdata;
   logic        mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   logic [31:0] mem [256];

   typedef struct {
      logic        port;
      logic        err;
      logic [31:0] data;
      logic        chk_data;
      int          cyc;
   } exp_t;

   exp_t sb [$];
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .p0_req    (p0_req),
      .p0_we     (p0_we),
      .p0_addr   (p0_addr),
      .p0_wdata  (p0_wdata),
      .p1_req    (p1_req),
      .p1_we     (p1_we),
      .p1_addr   (p1_addr),
      .p1_wdata  (p1_wdata),
      .p0_gnt    (p0_gnt),
      .p1_gnt    (p1_gnt),
      .p0_rvalid (p0_rvalid),
      .p1_rvalid (p1_rvalid),
      .p0_rdata  (p0_rdata),
      .p1_rdata  (p1_rdata),
      .p0_err    (p0_err),
      .p1_err    (p1_err),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
   end
   assign mem_rdata = mem[mem_addr[9:2]];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic set_in(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                         input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
      p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
      p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
   endtask

   // One cycle: check grant and mem_we, queue the expected response
   task automatic step(input string nm, input logic [1:0] eg, input logic eerr,
                       input logic [31:0] edata, input logic echk, input logic ewe);
      exp_t e;
      @(negedge clk);
      chk({nm, "_gnt"}, {30'b0, p1_gnt, p0_gnt}, {30'b0, eg});
      chk({nm, "_mem_we"}, {31'b0, mem_we}, {31'b0, ewe});
      if (eg != 2'b00) begin
         e.port = eg[1]; e.err = eerr; e.data = edata; e.chk_data = echk; e.cyc = cyc + 1;
         sb.push_back(e);
      end
      @(posedge clk); #1;
   endtask

   // Monitor: pops the scoreboard whenever a response pulse is presented
   always @(negedge clk) begin
      exp_t e;
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
         e = sb.pop_front();
         chk("missing_rvalid_cycle", cyc, e.cyc);
      end
      if (p0_rvalid && p1_rvalid) begin
         chk("rvalid_both", {30'b0, p1_rvalid, p0_rvalid}, 32'd1);
      end else if (p0_rvalid || p1_rvalid) begin
         if (sb.size() == 0) begin
            chk("unexpected_rvalid", {30'b0, p1_rvalid, p0_rvalid}, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("resp_port", {31'b0, p1_rvalid}, {31'b0, e.port});
            chk("resp_cycle", cyc, e.cyc);
            chk("resp_err", {31'b0, p1_rvalid ? p1_err : p0_err}, {31'b0, e.err});
            if (e.chk_data) chk("resp_rdata", p1_rvalid ? p1_rdata : p0_rdata, e.data);
            chk("idle_port_rdata", p1_rvalid ? p0_rdata : p1_rdata, 32'd0);
            chk("idle_port_err", {31'b0, p1_rvalid ? p0_err : p1_err}, 32'd0);
         end
      end
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + i;
      reset = 1'b1;
      set_in(1'b1, 1'b1, 32'h0, 32'h1111_1111, 1'b1, 1'b0, 32'h4, 32'h0);

      // Requests held during reset must not be granted
      @(negedge clk);
      chk("rst_gnt", {30'b0, p1_gnt, p0_gnt}, 32'd0);
      chk("rst_rvalid", {30'b0, p1_rvalid, p0_rvalid}, 32'd0);
      chk("rst_err", {30'b0, p1_err, p0_err}, 32'd0);
      chk("rst_rdata", p0_rdata | p1_rdata, 32'd0);
      chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
      @(posedge clk); #1;
      chk("rst_mem0_unchanged", mem[0], 32'hA000_0000);
      reset = 1'b0;

      // Both ports reading every cycle: strict alternation starting with p0
      for (int k = 0; k < 6; k++) begin
         set_in(1'b1, 1'b0, 32'h8 * ((k + 1) / 2), 32'h0,
                1'b1, 1'b0, 32'h4 + 32'h8 * (k / 2), 32'h0);
         step("contend", (k % 2 == 1) ? 2'b10 : 2'b01, 1'b0, 32'hA000_0000 + k, 1'b1, 1'b0);
      end

      set_in(1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 32'h0);
      step("p0_wr40", 2'b01, 1'b0, 32'h0, 1'b0, 1'b1);
      set_in(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      step("p0_rd40", 2'b01, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0);

      // Read-after-write across ports
      set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h80, 32'h0000_1234);
      step("p1_wr80", 2'b10, 1'b0, 32'h0, 1'b0, 1'b1);
      set_in(1'b1, 1'b0, 32'h80, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      step("p0_rd80", 2'b01, 1'b0, 32'h0000_1234, 1'b1, 1'b0);

      // Misaligned accesses are acknowledged with an error and never write
      set_in(1'b1, 1'b1, 32'h42, 32'h5555_5555, 1'b0, 1'b0, 32'h0, 32'h0);
      step("p0_mis_wr", 2'b01, 1'b1, 32'h0, 1'b1, 1'b0);
      set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h81, 32'h0);
      step("p1_mis_rd", 2'b10, 1'b1, 32'h0, 1'b1, 1'b0);
      set_in(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      step("p0_rd40_after_mis", 2'b01, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0);
      set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      step("idle_a", 2'b00, 1'b0, 32'h0, 1'b0, 1'b0);

      // Reset during a p1 write grant; last grant was p0 so p1 would win without it
      set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h84, 32'hCAFE_F00D);
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_p1_gnt", {31'b0, p1_gnt}, 32'd0);
      chk("midrst_mem_we", {31'b0, mem_we}, 32'd0);
      chk("midrst_rvalid", {30'b0, p1_rvalid, p0_rvalid}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      chk("midrst_mem84_unchanged", mem[33], 32'hA000_0021);
      set_in(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0);
      step("postrst_first", 2'b01, 1'b0, 32'hA000_0000, 1'b1, 1'b0);
      step("postrst_second", 2'b10, 1'b0, 32'hA000_0001, 1'b1, 1'b0);
      set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      step("idle_b", 2'b00, 1'b0, 32'h0, 1'b0, 1'b0);

      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("idle_gnt", {30'b0, p1_gnt, p0_gnt}, 32'd0);
         chk("idle_rvalid", {30'b0, p1_rvalid, p0_rvalid}, 32'd0);
         chk("idle_mem_we", {31'b0, mem_we}, 32'd0);
         chk("idle_mem_addr", mem_addr, 32'd0);
         @(posedge clk); #1;
      end

      @(negedge clk);
      chk("sb_empty", sb.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-ported data memory between the core load/store path (port 0) and a debug/loader master (port 1). It grants one word access per cycle under round-robin priority, drives the memory's write-enable, address and write-data inputs, and returns registered read data with a one-cycle valid pulse. Misaligned requests are rejected without touching memory. It sits between the requesters and the data memory, which has synchronous write and combinational read.

## Interface
- `ADDR_W`, default 32: byte-address width.
- `DATA_W`, default 32: data word width.
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high.
- `p0_req`, `p1_req` in 1: access request, held until granted.
- `p0_we`, `p1_we` in 1: 1 = write, 0 = read.
- `p0_addr`, `p1_addr` in ADDR_W: byte address, must be word aligned.
- `p0_wdata`, `p1_wdata` in DATA_W: write data.
- `p0_gnt`, `p1_gnt` out 1: request accepted this cycle (combinational).
- `p0_rvalid`, `p1_rvalid` out 1: response pulse, one cycle after grant.
- `p0_rdata`, `p1_rdata` out DATA_W: read data, valid with rvalid.
- `p0_err`, `p1_err` out 1: misaligned-access error, valid with rvalid.
- `mem_we` out 1: memory write enable.
- `mem_addr` out ADDR_W: byte address to memory.
- `mem_wdata` out DATA_W: memory write data.
- `mem_rdata` in DATA_W: memory combinational read data.

## Operation
- Requester contract: once `pX_req` rises, `pX_we`, `pX_addr` and `pX_wdata` stay stable until the cycle `pX_gnt` is high. `pX_req` may drop or re-assert in the cycle after a grant.
- Arbitration:
  - Only one requester: it is granted.
  - Both requesting: grant the port not granted most recently.
  - `last_grant` updates on every grant and resets to 1, so port 0 wins the first contest.
- Grant is combinational from the requests and `last_grant`. At most one `gnt` is high, and no grant is issued while `reset` is high.
- Granted and aligned (`addr[1:0]==0`):
  - `mem_addr`, `mem_wdata` and `mem_we` are muxed from the winner.
  - A write commits at the end of the grant cycle.
  - A read samples `mem_rdata` into the response register at the end of the grant cycle.
- Granted and misaligned:
  - `mem_we` is forced 0.
  - The response carries `err=1` and `rdata=0` for both reads and writes.
- Response register state:
  - `resp_valid`, `resp_port`, `resp_err`, `resp_data`.
  - `pX_rvalid = resp_valid && resp_port==X`. Writes also get an rvalid pulse as their completion acknowledgement.
  - `pX_rdata`/`pX_err` show the response values when that port's rvalid is high, and 0 otherwise.
- Idle cycle (no grant):
  - `mem_we=0`, and `mem_addr`/`mem_wdata` are 0.
  - `resp_valid` clears on the next edge.
- Reset values: all gnt/rvalid/err/rdata outputs 0, `mem_we=0`, `last_grant=1`.

## Timing
- Cycle N, request high and won: `gnt` high in N. The write lands at the rising edge that ends N.
- Cycle N+1: `rvalid` high for exactly one cycle, with read data equal to memory contents at the end of N.
- Throughput is one access per cycle. Back-to-back grants to the same port produce back-to-back rvalid pulses.
- Contention throughput: with both requesting continuously, grants alternate 0,1,0,1…
- Maximum wait for a requesting port is 1 cycle.
- Read-after-write to the same address:
  - Write granted in N, read granted in N+1.
  - The read returns the new data in N+2.
- Reset asserted mid-operation:
  - gnt and `mem_we` drop immediately (combinationally gated), so no write commits on an edge while reset is high.
  - Response registers clear asynchronously, and a pending rvalid is lost.
  - `last_grant` returns to 1.
- Reset deasserted: the first grant may occur in the first cycle after release.

## Structure
- Package `dmem_arb_pkg`:
  - `ADDR_W`/`DATA_W` defaults.
  - `port_id_t` enum (`PORT_CORE=0`, `PORT_DBG=1`).
  - Response struct type `{valid, port, err, data}`.
- Sub-module `rr_arb2`: two-input round-robin picker.
  - Inputs: `req[1:0]`, `last_grant`.
  - Outputs: one-hot `gnt[1:0]`, `gnt_id`.
  - Combinational. The `last_grant` flop lives in `dmem_arbiter`.
- Top level holds the mux, the alignment check, the response register and the reset gating.

## Test plan
- Port 0 writes `0xDEADBEEF` to `0x40` alone:
  - `p0_gnt` in cycle 0, `p0_rvalid` in cycle 1 with `err=0`.
  - A following p0 read of `0x40` returns `0xDEADBEEF` one cycle after its grant.
- Both ports request reads every cycle for 6 cycles after reset:
  - Grants go p0,p1,p0,p1,p0,p1.
  - Each rvalid arrives one cycle after its grant with correct data and the correct port.
- p1 writes `0x1234` to `0x80` in cycle N, p0 reads `0x80` in N+1:
  - p0 receives `0x1234` in N+2.
- p0 requests a write to `0x42`:
  - `gnt` in N, `mem_we` stays 0, memory is unchanged.
  - `p0_rvalid=1`, `p0_err=1`, `p0_rdata=0` in N+1.
- Reset asserted during a p1 write grant cycle:
  - `mem_we` and `p1_gnt` drop immediately, the target word is unchanged, and all rvalid are 0.
  - After release, a simultaneous p0/p1 request grants p0 first.
- Idle with no requests for 5 cycles: all gnt, rvalid and `mem_we` stay 0, and `mem_addr` is 0.
